// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline register chain.
// Build option: PIPE_SKID_EN adds a one-entry skid register per slot.
package pipe_pkg;

  localparam int PIPE_MAX_DEPTH = 8;

`ifdef PIPE_SKID_EN
  localparam int PIPE_SLOT_CAP = 2;
`else
  localparam int PIPE_SLOT_CAP = 1;
`endif

  // Occupancy flags of one slot; skid stays 0 without PIPE_SKID_EN.
  typedef struct packed {
    logic valid;
    logic skid;
  } slot_flags_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline slot: valid flag, data register and, with PIPE_SKID_EN,
// a skid entry. Ports: in_* upstream handshake, out_* downstream, occ 0..2.
module pipe_stage_cell
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 64,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  slot_flags_t      flags_q, flags_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             accept;

`ifdef PIPE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             leave;

  // Ready is purely registered: the slot takes a beat whenever
  // the skid entry is free, even if downstream stalls.
  always_comb begin
    in_ready = ~flags_q.skid;
    accept   = in_valid & in_ready;
    leave    = flags_q.valid & out_ready;
    flags_d  = flags_q;
    data_d   = data_q;
    skid_d   = skid_q;
    if (flush) begin
      flags_d = '0;
      data_d  = RESET_DATA;
      skid_d  = RESET_DATA;
    end else if (flags_q.skid) begin
      // skid drains into the main slot before new input
      if (leave) begin
        data_d       = skid_q;
        flags_d.skid = 1'b0;
      end
    end else if (~flags_q.valid | leave) begin
      flags_d.valid = accept;
      if (accept) data_d = in_data;
    end else if (accept) begin
      flags_d.skid = 1'b1;
      skid_d       = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) skid_q <= RESET_DATA;
    else       skid_q <= skid_d;
  end
`else
  always_comb begin
    in_ready = ~flags_q.valid | out_ready;
    accept   = in_valid & in_ready;
    flags_d  = flags_q;
    data_d   = data_q;
    if (flush) begin
      flags_d = '0;
      data_d  = RESET_DATA;
    end else if (accept) begin
      flags_d.valid = 1'b1;
      data_d        = in_data;
    end else if (out_ready) begin
      flags_d.valid = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      data_q  <= RESET_DATA;
    end else begin
      flags_q <= flags_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = flags_q.valid;
  assign out_data  = data_q;
  assign occ = {1'b0, flags_q.valid} + {1'b0, flags_q.skid};

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH chained pipeline slots with valid/ready, flush and occupancy.
// Ports: clk, reset, flush, in_valid/in_ready/in_data,
// out_valid/out_ready/out_data, occupancy. Option macro: PIPE_SKID_EN.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 64,
  parameter int               DEPTH      = 1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0,
  localparam int              CAP        = DEPTH * PIPE_SLOT_CAP,
  localparam int              OCC_W      = clog2(CAP + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
    $error("pipe_stage_chain: DEPTH must be 1..%0d", PIPE_MAX_DEPTH);
  end

  // Link k sits in front of cell k; link DEPTH is the chain output.
  logic             c_valid [DEPTH+1];
  logic             c_ready [DEPTH+1];
  logic [WIDTH-1:0] c_data  [DEPTH+1];
  logic [1:0]       c_occ   [DEPTH];
  logic [OCC_W-1:0] occ_sum;

  assign c_valid[0]     = in_valid;
  assign c_data[0]      = in_data;
  assign c_ready[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    pipe_stage_cell #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (c_valid[i]),
      .in_ready  (c_ready[i]),
      .in_data   (c_data[i]),
      .out_valid (c_valid[i+1]),
      .out_ready (c_ready[i+1]),
      .out_data  (c_data[i+1]),
      .occ       (c_occ[i])
    );
  end

  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_sum = occ_sum + OCC_W'(c_occ[i]);
    end
  end

  // A flushing chain never accepts the beat on offer.
  assign in_ready  = c_ready[0] & ~flush;
  assign out_valid = c_valid[DEPTH];
  assign out_data  = c_data[DEPTH];
  assign occupancy = occ_sum;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain.
// Several instances cover DEPTH=3/2/1 and WIDTH=64/8/1.
module tb_pipe_stage_chain;

`ifdef PIPE_SKID_EN
  localparam int SK = 2;
`else
  localparam int SK = 1;
`endif
  localparam logic [63:0] A_RST = 64'hDEAD_BEEF_0000_0001;
  localparam logic [7:0]  B_RST = 8'h5A;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  logic        a_fl, a_iv, a_ir, a_ov, a_or;
  logic [63:0] a_id, a_od;
  logic [$clog2(3*SK+1)-1:0] a_occ;

  logic        b_fl, b_iv, b_ir, b_ov, b_or;
  logic [7:0]  b_id, b_od;
  logic [$clog2(2*SK+1)-1:0] b_occ;

  logic        c_fl, c_iv, c_ir, c_ov, c_or;
  logic [0:0]  c_id, c_od;
  logic [$clog2(SK+1)-1:0] c_occ;

  pipe_stage_chain #(.WIDTH(64), .DEPTH(3), .RESET_DATA(A_RST)) u_a (
    .clk(clk), .reset(reset), .flush(a_fl),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .occupancy(a_occ)
  );

  pipe_stage_chain #(.WIDTH(8), .DEPTH(2), .RESET_DATA(B_RST)) u_b (
    .clk(clk), .reset(reset), .flush(b_fl),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .occupancy(b_occ)
  );

  pipe_stage_chain #(.WIDTH(1), .DEPTH(1), .RESET_DATA(1'b1)) u_c (
    .clk(clk), .reset(reset), .flush(c_fl),
    .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
    .occupancy(c_occ)
  );

`ifdef PIPE_SKID_EN
  logic       d_iv, d_ir, d_ov, d_or;
  logic [7:0] d_id, d_od;
  logic [1:0] d_occ;

  pipe_stage_chain #(.WIDTH(8), .DEPTH(1), .RESET_DATA(8'h00)) u_d (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id),
    .out_valid(d_ov), .out_ready(d_or), .out_data(d_od),
    .occupancy(d_occ)
  );
`endif

  typedef struct {
    int iv, id, rdy, fl;
    int e_ir, e_ov, e_od, e_occ;
  } vec_t;

  vec_t        tbl [9];
  logic [63:0] q [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // iv id rdy fl | in_ready out_valid out_data occ
    tbl[0] = '{1, 0, 0, 0, 1, 1, 0, 1};
    tbl[1] = '{1, 1, 0, 0, 0, 1, 0, 1};
    tbl[2] = '{1, 1, 1, 0, 1, 1, 1, 1};
    tbl[3] = '{0, 0, 1, 0, 1, 0, 1, 0};
    tbl[4] = '{0, 0, 0, 0, 1, 0, 1, 0};
    tbl[5] = '{1, 0, 1, 0, 1, 1, 0, 1};
    tbl[6] = '{1, 1, 0, 1, 0, 0, 1, 0};
    tbl[7] = '{1, 0, 0, 0, 1, 1, 0, 1};
    tbl[8] = '{0, 0, 1, 1, 0, 0, 1, 0};

    // reset held two cycles while upstream offers data
    reset = 1'b1;
    a_fl = 0; a_iv = 1; a_or = 1; a_id = 64'h77;
    b_fl = 0; b_iv = 1; b_or = 1; b_id = 8'h77;
    c_fl = 0; c_iv = 1; c_or = 1; c_id = 1'b0;
`ifdef PIPE_SKID_EN
    d_iv = 1; d_or = 1; d_id = 8'h77;
`endif
    tick();
    tick();
    chk("rst_a_valid", a_ov, 0);
    chk("rst_a_occ", a_occ, 0);
    chk("rst_a_data", a_od, A_RST);
    chk("rst_b_data", b_od, B_RST);
    chk("rst_c_data", c_od, 1);
    reset = 1'b0;
    a_iv = 0; b_iv = 0; c_iv = 0;
`ifdef PIPE_SKID_EN
    d_iv = 0;
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_no_beat", a_ov, 0);
    end

`ifndef PIPE_SKID_EN
    // single-slot WIDTH=1 table
    for (int i = 0; i < 9; i++) begin
      c_iv = 1'(tbl[i].iv);
      c_id = 1'(tbl[i].id);
      c_or = 1'(tbl[i].rdy);
      c_fl = 1'(tbl[i].fl);
      #2;
      chk($sformatf("tbl%0d_in_ready", i), c_ir, 64'(tbl[i].e_ir));
      tick();
      chk($sformatf("tbl%0d_out_valid", i), c_ov, 64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_out_data", i), c_od, 64'(tbl[i].e_od));
      chk($sformatf("tbl%0d_occ", i), c_occ, 64'(tbl[i].e_occ));
    end
    c_iv = 0; c_fl = 0;
`endif

    // DEPTH=3 latency: 1,2,3 leave after edges 3,4,5
    a_or = 1;
    for (int k = 1; k <= 6; k++) begin
      a_iv = (k <= 3);
      a_id = 64'(k);
      tick();
      if (k >= 3 && k <= 5) begin
        chk($sformatf("lat_valid_c%0d", k), a_ov, 1);
        chk($sformatf("lat_data_c%0d", k), a_od, 64'(k - 2));
      end else if (k == 6) begin
        chk("lat_valid_end", a_ov, 0);
      end
    end

`ifndef PIPE_SKID_EN
    // DEPTH=2 stall: third beat held upstream
    b_or = 0; b_iv = 1;
    b_id = 8'h0A; #2; chk("stall_rdy_a", b_ir, 1); tick();
    b_id = 8'h0B; #2; chk("stall_rdy_b", b_ir, 1); tick();
    b_id = 8'h0C; #2;
    chk("stall_rdy_c", b_ir, 0);
    chk("stall_occ", b_occ, 2);
    chk("stall_head", b_od, 8'h0A);
    tick();
    chk("stall_hold", b_od, 8'h0A);
    chk("stall_hold_occ", b_occ, 2);
    b_or = 1; #2;
    chk("release_rdy", b_ir, 1);
    tick();
    chk("release_b_valid", b_ov, 1);
    chk("release_b", b_od, 8'h0B);
    b_iv = 0;
    tick();
    chk("release_c_valid", b_ov, 1);
    chk("release_c", b_od, 8'h0C);
    tick();
    chk("release_empty", b_ov, 0);
    chk("release_occ", b_occ, 0);
`endif

    // flush of a full chain drops the beat on offer
    b_or = 0; b_iv = 1;
    b_id = 8'h11; tick();
    b_id = 8'h22; tick();
    b_fl = 1; b_id = 8'h33; #2;
    chk("flush_rdy", b_ir, 0);
    chk("flush_pre_valid", b_ov, 1);
    chk("flush_pre_occ", b_occ, 2);
    tick();
    b_fl = 0; b_iv = 0;
    chk("flush_occ", b_occ, 0);
    chk("flush_valid", b_ov, 0);
    chk("flush_data", b_od, B_RST);
    b_or = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("flush_no_33", b_ov, 0);
    end

`ifdef PIPE_SKID_EN
    begin
      logic [7:0] got [$];
      int         sent;
      int         peak;
      sent = 0; peak = 0;
      for (int k = 0; k < 40 && got.size() < 8; k++) begin
        d_or = (k % 2 == 0);
        d_iv = (sent < 8);
        d_id = 8'(8'hC0 + sent);
        @(negedge clk);
        chk("skid_ready_reg", d_ir, (d_occ != 2'd2));
        if (d_ov && d_or) got.push_back(d_od);
        if (d_iv && d_ir) sent++;
        @(posedge clk); #1;
        if (int'(d_occ) > peak) peak = int'(d_occ);
      end
      chk("skid_count", got.size(), 8);
      for (int i = 0; i < got.size(); i++)
        chk($sformatf("skid_order%0d", i), got[i], 8'(8'hC0 + i));
      chk("skid_peak", peak, 2);
      d_iv = 0;
    end
`endif

    // random valid/ready against a scoreboard queue
    for (int k = 0; k < 10000; k++) begin
      a_iv = 1'($urandom_range(0, 1));
      a_id = {$urandom, $urandom};
      a_or = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (a_ov && a_or) begin
        chk("rand_nonempty", (q.size() != 0), 1);
        if (q.size() != 0) chk("rand_data", a_od, q.pop_front());
      end
      if (a_iv && a_ir) q.push_back(a_id);
      @(posedge clk); #1;
      chk("rand_occ", a_occ, q.size());
    end
    a_iv = 0; a_or = 1;
    for (int k = 0; k < 20 && q.size() != 0; k++) begin
      @(negedge clk);
      if (a_ov) chk("drain_data", a_od, q.pop_front());
      @(posedge clk); #1;
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_occ", a_occ, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
